jtag_shift_sequencer: RTL and testbench
=======================================

JTAG_SHIFT_SEQUENCER -- requirements
Module: jtag_shift_sequencer

Interface
REQ-001 SHALL have parameter TICK_DELAY, default 1, meaning clocks per TCK half-period minus one (>=0).
REQ-002 SHALL have port clock  in  1  sole clock.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-005 SHALL have port cmd_op  in  2  opcode: 0 SHIFT_DR, 1 SHIFT_IR, 2 TAP_RESET, 3 RUN_IDLE.
REQ-006 SHALL have port cmd_len  in  6  bit count minus one (1..64 bits or idle TCKs).
REQ-007 SHALL have port cmd_tdi  in  64  shift-in data, LSB first.
REQ-008 SHALL have port resp_valid/resp_ready  out/in  1/1  response handshake.
REQ-009 SHALL have port resp_tdo  out  64  captured TDO, LSB = first bit shifted.
REQ-010 SHALL have ports jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn  out  1 each  JTAG master pins.
REQ-011 SHALL have ports jtag_TDO_data, jtag_TDO_driven  in  1 each  target TDO and its output enable.

Function
REQ-012 TCK SHALL toggle every TICK_DELAY+1 clocks only while an operation is active; held low otherwise.
REQ-013 TMS/TDI SHALL change only in the clock after a TCK falling edge; TDO SHALL be sampled in the clock of the TCK rising edge.
REQ-014 Sampled TDO SHALL be jtag_TDO_data when jtag_TDO_driven, else 0.
REQ-015 States: BOOT_RESET, IDLE, PRE, SHIFT, POST, RESP; IDLE is the only state asserting cmd_ready.
REQ-016 Command accepted on cmd_valid&&cmd_ready; the first TCK low phase SHALL begin the next clock.
REQ-017 SHIFT_DR TMS per rising edge: PRE 1,0,0; SHIFT n edges TMS 0 except last TMS 1; POST 1,0 (n+5 TCKs).
REQ-018 SHIFT_IR TMS per rising edge: PRE 1,1,0,0; SHIFT as REQ-017; POST 1,0 (n+6 TCKs).
REQ-019 During SHIFT, TDI SHALL present cmd_tdi[i] at edge i; TDI SHALL be 0 outside SHIFT.
REQ-020 resp_tdo[i] SHALL hold the TDO sampled at shift edge i; bits i>=n SHALL be 0.
REQ-021 TAP_RESET SHALL issue 5 edges TMS=1 then 1 edge TMS=0; RUN_IDLE SHALL issue cmd_len+1 edges TMS=0; both respond with resp_tdo=0.
REQ-022 After the final TCK falling edge, state RESP SHALL assert resp_valid, resp_tdo stable, until resp_ready; then IDLE next clock.
REQ-023 Only one command SHALL be outstanding; cmd_ready SHALL be 0 from acceptance until the response is consumed.
REQ-024 The TAP SHALL always be left in Run-Test/Idle between commands.

Reset
REQ-025 During reset: TCK=0, TMS=1, TDI=0, TRSTn=0, cmd_ready=0, resp_valid=0, resp_tdo=0.
REQ-026 After reset release TRSTn SHALL go 1 and BOOT_RESET SHALL run the TAP_RESET sequence with no response, then enter IDLE.
REQ-027 Reset asserted mid-operation SHALL abort immediately to REQ-025 values; the in-flight command is dropped with no response.

Structure
REQ-028 A shared package SHALL hold the opcode enum, state enum, MAX_BITS=64 and length width.
REQ-029 One sub-module jtag_tck_gen SHALL generate TCK plus rise/fall strobes from TICK_DELAY and an enable.

Verification (TICK_DELAY=1, TDO loopback = TDI unless stated)
REQ-030 Reset release -> TRSTn=1, 5 TCK rises TMS=1, 1 rise TMS=0, then cmd_ready=1; no resp_valid.
REQ-031 SHIFT_IR len=4 tdi=0x15 -> 11 TCKs, TMS 1,1,0,0,0,0,0,0,1,1,0; TDI 1,0,1,0,1 on shift edges; resp_tdo=0x15; TCK period 4 clocks.
REQ-032 SHIFT_DR len=63 tdi=all-ones, jtag_TDO_driven=0 -> 69 TCKs, resp_tdo=0.
REQ-033 SHIFT_DR len=7 tdi=0xA5 with resp_ready=0 for 20 clocks -> resp_valid held, resp_tdo=0xA5 stable, cmd_ready=0 until handshake.
REQ-034 Reset asserted at shift edge 3 of a 16-bit SHIFT_DR -> outputs at REQ-025 values same clock, no response, boot sequence reruns.
REQ-035 RUN_IDLE len=9 back-to-back with TAP_RESET -> 10 rises TMS=0, then 5x TMS=1 + 1x TMS=0, two responses with resp_tdo=0 in order.

Source files
------------

// File: rtl/jtag_shift_sequencer_pkg.sv
// rtl/jtag_shift_sequencer_pkg.sv - shared opcodes, states, sizes and TMS pattern helpers
package jtag_shift_sequencer_pkg;

  localparam int MAX_BITS = 64;
  localparam int LEN_W    = 6;

  typedef enum logic [1:0] {
    OP_SHIFT_DR  = 2'd0,
    OP_SHIFT_IR  = 2'd1,
    OP_TAP_RESET = 2'd2,
    OP_RUN_IDLE  = 2'd3
  } jtag_op_e;

  typedef enum logic [2:0] {
    ST_BOOT_RESET = 3'd0,
    ST_IDLE       = 3'd1,
    ST_PRE        = 3'd2,
    ST_SHIFT      = 3'd3,
    ST_POST       = 3'd4,
    ST_RESP       = 3'd5
  } seq_state_e;

  // TMS to present for the rising edge identified by (state, cnt)
  function automatic logic tms_for(seq_state_e st, jtag_op_e op,
                                   logic [LEN_W-1:0] cnt, logic [LEN_W-1:0] len);
    logic t;
    t = 1'b0;
    case (st)
      ST_BOOT_RESET: t = (cnt < LEN_W'(5));
      ST_PRE: begin
        case (op)
          OP_SHIFT_DR:  t = (cnt == LEN_W'(0));
          OP_SHIFT_IR:  t = (cnt < LEN_W'(2));
          OP_TAP_RESET: t = (cnt < LEN_W'(5));
          default:      t = 1'b0;
        endcase
      end
      ST_SHIFT: t = (cnt == len);
      ST_POST:  t = (cnt == LEN_W'(0));
      default:  t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic pre_last(jtag_op_e op, logic [LEN_W-1:0] cnt,
                                    logic [LEN_W-1:0] len);
    logic l;
    case (op)
      OP_SHIFT_DR:  l = (cnt == LEN_W'(2));
      OP_SHIFT_IR:  l = (cnt == LEN_W'(3));
      OP_TAP_RESET: l = (cnt == LEN_W'(5));
      default:      l = (cnt == len);
    endcase
    return l;
  endfunction

endpackage

// File: rtl/jtag_shift_sequencer_tck_gen.sv
// rtl/jtag_shift_sequencer_tck_gen.sv - TCK divider with rise/fall strobes, low while disabled
module jtag_tck_gen #(
  parameter int TICK_DELAY = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (TICK_DELAY > 0) ? $clog2(TICK_DELAY + 1) : 1;
  localparam logic [CW-1:0] TOP = CW'(TICK_DELAY);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          tick;

  assign tick   = en_i && (cnt_q == TOP);
  assign rise_o = tick && !tck_q;
  assign fall_o = tick && tck_q;
  assign tck_o  = tck_q;

  always_comb begin
    cnt_d = '0;
    tck_d = 1'b0;
    if (en_i) begin
      if (cnt_q == TOP) begin
        cnt_d = '0;
        tck_d = ~tck_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
        tck_d = tck_q;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

endmodule

// File: rtl/jtag_shift_sequencer.sv
// rtl/jtag_shift_sequencer.sv - JTAG master executing DR/IR shifts, TAP reset and idle clocking
module jtag_shift_sequencer
  import jtag_shift_sequencer_pkg::*;
#(
  parameter int TICK_DELAY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [MAX_BITS-1:0] cmd_tdi,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [MAX_BITS-1:0] resp_tdo,
  output logic                jtag_TCK,
  output logic                jtag_TMS,
  output logic                jtag_TDI,
  output logic                jtag_TRSTn,
  input  logic                jtag_TDO_data,
  input  logic                jtag_TDO_driven
);

  seq_state_e          state_q, state_d;
  jtag_op_e            op_q, op_d;
  logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d;
  logic [MAX_BITS-1:0] data_q, data_d, tdo_q, tdo_d;
  logic                tms_q, tms_d, tdi_q, tdi_d, trstn_q;
  logic                tck_en, tck_rise, tck_fall;

  assign tck_en = (state_q == ST_BOOT_RESET) || (state_q == ST_PRE) ||
                  (state_q == ST_SHIFT) || (state_q == ST_POST);

  jtag_tck_gen #(.TICK_DELAY(TICK_DELAY)) u_tck (
    .clock  (clock),
    .reset  (reset),
    .en_i   (tck_en),
    .tck_o  (jtag_TCK),
    .rise_o (tck_rise),
    .fall_o (tck_fall)
  );

  // (state, cnt) names the next rising edge; it advances on each falling edge
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    tdo_d   = tdo_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) begin
        state_d = ST_PRE;
        op_d    = jtag_op_e'(cmd_op);
        len_d   = cmd_len;
        cnt_d   = '0;
        data_d  = cmd_tdi;
        tdo_d   = '0;
      end
      ST_BOOT_RESET: if (tck_fall) begin
        if (cnt_q == LEN_W'(5)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      ST_PRE: if (tck_fall) begin
        if (pre_last(op_q, cnt_q, len_q)) begin
          cnt_d   = '0;
          state_d = (op_q == OP_SHIFT_DR || op_q == OP_SHIFT_IR) ? ST_SHIFT : ST_RESP;
        end else cnt_d = cnt_q + 1'b1;
      end
      ST_SHIFT: begin
        if (tck_rise) tdo_d[cnt_q] = jtag_TDO_driven & jtag_TDO_data;
        if (tck_fall) begin
          if (cnt_q == len_q) begin
            state_d = ST_POST;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 1'b1;
        end
      end
      ST_POST: if (tck_fall) begin
        if (cnt_q == LEN_W'(1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    tms_d = tms_for(state_d, op_d, cnt_d, len_d);
    tdi_d = (state_d == ST_SHIFT) ? data_d[cnt_d] : 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT_RESET;
      op_q    <= OP_TAP_RESET;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      tdo_q   <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      trstn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tdo_q   <= tdo_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      trstn_q <= 1'b1;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_tdo   = tdo_q;
  assign jtag_TMS   = tms_q;
  assign jtag_TDI   = tdi_q;
  assign jtag_TRSTn = trstn_q;

endmodule

// File: tb/tb_jtag_shift_sequencer.sv
// tb/tb_jtag_shift_sequencer.sv - table-driven scoreboard bench for jtag_shift_sequencer
module tb_jtag_shift_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, resp_valid, resp_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic [63:0] cmd_tdi, resp_tdo;
  logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, tdo_driven;
  wire         tdo_loop = jtag_TDI;

  jtag_shift_sequencer #(.TICK_DELAY(1)) dut (
    .clock           (clock),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_len         (cmd_len),
    .cmd_tdi         (cmd_tdi),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_tdo        (resp_tdo),
    .jtag_TCK        (jtag_TCK),
    .jtag_TMS        (jtag_TMS),
    .jtag_TDI        (jtag_TDI),
    .jtag_TRSTn      (jtag_TRSTn),
    .jtag_TDO_data   (tdo_loop),
    .jtag_TDO_driven (tdo_driven)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  len;
    logic [63:0] tdi;
    logic        driven;
    logic [63:0] exp_tdo;
    int          exp_rises;
    int          hold;
  } vec_t;

  int          checks = 0, failures = 0;
  int          cyc = 0, resp_count = 0, rv_cycles = 0;
  bit          prev_tck = 1'b0;
  bit          tms_log[$], tdi_log[$];
  int          rise_cyc[$];
  logic [63:0] exp_q[$];
  vec_t        vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    if (reset) prev_tck = 1'b0;
    else begin
      if (jtag_TCK && !prev_tck) begin
        tms_log.push_back(jtag_TMS);
        tdi_log.push_back(jtag_TDI);
        rise_cyc.push_back(cyc);
      end
      prev_tck = jtag_TCK;
      if (resp_valid) rv_cycles++;
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) check("resp_unexpected", 64'd1, 64'd0);
        else check("resp_tdo", resp_tdo, exp_q.pop_front());
        resp_count++;
      end
    end
  end

  task automatic clear_logs();
    tms_log.delete();
    tdi_log.delete();
    rise_cyc.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tck"}, 64'(jtag_TCK), 64'd0);
    check({tag, "_tms"}, 64'(jtag_TMS), 64'd1);
    check({tag, "_tdi"}, 64'(jtag_TDI), 64'd0);
    check({tag, "_trstn"}, 64'(jtag_TRSTn), 64'd0);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    check({tag, "_resp_tdo"}, resp_tdo, 64'd0);
  endtask

  // Expected TMS per rising edge and TDI per edge, derived from the opcode
  task automatic check_trace(input string tag, input logic [1:0] op, input logic [5:0] len,
                             input logic [63:0] tdi);
    bit m[$];
    int pre, tms_bad, tdi_bad;
    logic exp_tdi;
    pre = 0;
    case (op)
      2'd0: begin m = '{1'b1, 1'b0, 1'b0}; pre = 3; end
      2'd1: begin m = '{1'b1, 1'b1, 1'b0, 1'b0}; pre = 4; end
      2'd2: m = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      default: for (int i = 0; i <= int'(len); i++) m.push_back(1'b0);
    endcase
    if (op <= 2'd1) begin
      for (int i = 0; i <= int'(len); i++) m.push_back(i == int'(len));
      m.push_back(1'b1);
      m.push_back(1'b0);
    end
    tms_bad = (m.size() == tms_log.size()) ? 0 : 1000;
    tdi_bad = 0;
    for (int j = 0; j < tms_log.size() && j < m.size(); j++) begin
      if (tms_log[j] != m[j]) tms_bad++;
      exp_tdi = (op <= 2'd1 && j >= pre && j <= pre + int'(len)) ? tdi[j - pre] : 1'b0;
      if (tdi_log[j] != exp_tdi) tdi_bad++;
    end
    check({tag, "_tms_seq"}, 64'(tms_bad), 64'd0);
    check({tag, "_tdi_seq"}, 64'(tdi_bad), 64'd0);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clock); #1;
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_cmd_ready_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_cmd(input string tag, input vec_t v);
    bit ok;
    int bad, rc;
    wait_ready(ok);
    if (!ok) return;
    clear_logs();
    cmd_op = v.op; cmd_len = v.len; cmd_tdi = v.tdi; tdo_driven = v.driven;
    cmd_valid = 1'b1;
    exp_q.push_back(v.exp_tdo);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    check({tag, "_busy"}, 64'(cmd_ready), 64'd0);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    if (!ok) begin
      check({tag, "_resp_timeout"}, 64'd1, 64'd0);
      return;
    end
    bad = 0;
    for (int k = 0; k < v.hold; k++) begin
      if (!resp_valid || resp_tdo !== v.exp_tdo || cmd_ready || jtag_TCK) bad++;
      @(posedge clock); #1;
    end
    if (v.hold > 0) check({tag, "_resp_hold"}, 64'(bad), 64'd0);
    rc = resp_count;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    check({tag, "_idle_after_resp"}, 64'(cmd_ready), 64'd1);
    check({tag, "_resp_count"}, 64'(resp_count), 64'(rc + 1));
    check({tag, "_rises"}, 64'(tms_log.size()), 64'(v.exp_rises));
    check_trace(tag, v.op, v.len, v.tdi);
  endtask

  initial begin
    bit ok;
    int rc, rv;
    vecs[0] = '{2'd1, 6'd4,  64'h15,                 1'b1, 64'h15,                 11, 0};
    vecs[1] = '{2'd0, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0,                  69, 0};
    vecs[2] = '{2'd0, 6'd7,  64'hA5,                 1'b1, 64'hA5,                 13, 20};
    vecs[3] = '{2'd0, 6'd0,  64'h1,                  1'b1, 64'h1,                  6,  0};
    vecs[4] = '{2'd0, 6'd15, 64'hBEEF,               1'b1, 64'hBEEF,               21, 0};
    vecs[5] = '{2'd1, 6'd7,  64'h3C0,                1'b1, 64'hC0,                 14, 0};
    vecs[6] = '{2'd0, 6'd63, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0123_4567_89AB_CDEF, 69, 0};
    vecs[7] = '{2'd3, 6'd9,  64'hFFFF,               1'b1, 64'h0,                  10, 0};
    vecs[8] = '{2'd2, 6'd0,  64'hFFFF,               1'b1, 64'h0,                  6,  0};

    reset = 1'b1; cmd_valid = 1'b0; resp_ready = 1'b0;
    cmd_op = '0; cmd_len = '0; cmd_tdi = '0; tdo_driven = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals("por");
    clear_logs();
    reset = 1'b0;
    wait_ready(ok);
    check("boot_trstn", 64'(jtag_TRSTn), 64'd1);
    check("boot_rises", 64'(tms_log.size()), 64'd6);
    check_trace("boot", 2'd2, 6'd0, 64'd0);
    check("boot_no_resp", 64'(rv_cycles), 64'd0);

    for (int i = 0; i < 9; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i]);
      if (i == 0 && rise_cyc.size() >= 2)
        check("tck_period", 64'(rise_cyc[1] - rise_cyc[0]), 64'd4);
    end
    check("resp_all_consumed", 64'(exp_q.size()), 64'd0);

    // Abort a 16-bit DR shift at shift edge 3 (seventh rising edge overall)
    wait_ready(ok);
    clear_logs();
    cmd_op = 2'd0; cmd_len = 6'd15; cmd_tdi = 64'hFFFF; cmd_valid = 1'b1;
    exp_q.push_back(64'hFFFF);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tms_log.size() >= 7) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    check("abort_reached_edge", 64'(ok), 64'd1);
    check("abort_tck_high", 64'(jtag_TCK), 64'd1);
    rc = resp_count;
    rv = rv_cycles;
    reset = 1'b1;
    #1;
    check_reset_vals("abort");
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    clear_logs();
    reset = 1'b0;
    wait_ready(ok);
    check("reboot_rises", 64'(tms_log.size()), 64'd6);
    check_trace("reboot", 2'd2, 6'd0, 64'd0);
    check("abort_no_resp", 64'(resp_count), 64'(rc));
    check("abort_no_resp_valid", 64'(rv_cycles), 64'(rv));
    run_cmd("post_abort", '{2'd0, 6'd3, 64'h9, 1'b1, 64'h9, 9, 0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
